// File: rtl/tx_ctrl.sv
// tx_ctrl: frame controller for the 8-bit TX shift register.
// Handshakes a byte in, loads the shift register and frames start/data/stop bits.
module tx_ctrl #(
    parameter int CLKS_PER_BIT = 10,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_req,
    input  logic [7:0] tx_data_in,
    output logic       tx_ack,
    output logic [7:0] tx_data,
    output logic       load_data,
    output logic       tx_enable,
    output logic       shift_strobe,
    input  logic       sr_out,
    output logic       serial_line,
    output logic       busy
);

    localparam int TW = $clog2(2 * CLKS_PER_BIT);

    // Last timer value of one bit, the value one cycle before it, and end of stop.
    localparam logic [TW-1:0] T_BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_PRE_LAST  = TW'(CLKS_PER_BIT - 2);
    localparam logic [TW-1:0] T_STOP_LAST = TW'(STOP_BITS * CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_tim;
    logic [2:0]      r_bit;
    logic [7:0]      r_tx_data;
    logic            r_load;
    logic            r_en;
    logic            r_strobe;
    logic            r_busy;
    logic            w_line;
    logic            w_ack;

    // Ack is combinational so the byte is accepted in the same IDLE cycle.
    assign w_ack = n_rst & tx_req & (r_state == S_IDLE);

    assign tx_ack       = w_ack;
    assign tx_data      = r_tx_data;
    assign load_data    = r_load;
    assign tx_enable    = r_en;
    assign shift_strobe = r_strobe;
    assign busy         = r_busy;
    assign serial_line  = w_line;

    // Frame sequencer; the strobe is pre-computed so it lands on the last bit cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= S_IDLE;
            r_tim     <= '0;
            r_bit     <= '0;
            r_tx_data <= '0;
            r_load    <= 1'b0;
            r_en      <= 1'b0;
            r_strobe  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_load   <= 1'b0;
            r_strobe <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (tx_req) begin
                        r_tx_data <= tx_data_in;
                        r_state   <= S_LOAD;
                        r_load    <= 1'b1;
                        r_busy    <= 1'b1;
                        r_tim     <= '0;
                    end
                end
                S_LOAD: begin
                    r_state <= S_START;
                    r_tim   <= '0;
                end
                S_START: begin
                    if (r_tim == T_BIT_LAST) begin
                        r_state <= S_DATA;
                        r_tim   <= '0;
                        r_bit   <= '0;
                        r_en    <= 1'b1;
                    end else begin
                        r_tim <= r_tim + 1'b1;
                    end
                end
                S_DATA: begin
                    r_strobe <= (r_tim == T_PRE_LAST);
                    if (r_tim == T_BIT_LAST) begin
                        r_tim <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                            r_bit   <= '0;
                            r_en    <= 1'b0;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_tim <= r_tim + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_tim == T_STOP_LAST) begin
                        r_state <= S_IDLE;
                        r_tim   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_tim <= r_tim + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tim   <= '0;
                    r_bit   <= '0;
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Line mux: low start bit, shift register data, high otherwise.
    always_comb begin
        w_line = 1'b1;
        case (r_state)
            S_START: w_line = 1'b0;
            S_DATA:  w_line = sr_out;
            default: w_line = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_tx_ctrl.sv
// tb_tx_ctrl: random and directed frames on two tx_ctrl configurations,
// each driving a behavioural MSB-first shift register.
module tb_tx_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_rst;

    logic       a_req, b_req;
    logic [7:0] a_din, b_din;
    logic       a_ack, a_load, a_en, a_stb, a_sro, a_line, a_busy;
    logic       b_ack, b_load, b_en, b_stb, b_sro, b_line, b_busy;
    logic [7:0] a_txd, b_txd;
    logic [7:0] a_sr, b_sr;

    int n_chk = 0;
    int n_fail = 0;

    tx_ctrl #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_a (
        .clk(clk), .n_rst(n_rst), .tx_req(a_req), .tx_data_in(a_din),
        .tx_ack(a_ack), .tx_data(a_txd), .load_data(a_load),
        .tx_enable(a_en), .shift_strobe(a_stb), .sr_out(a_sro),
        .serial_line(a_line), .busy(a_busy)
    );

    tx_ctrl #(.CLKS_PER_BIT(3), .STOP_BITS(2)) u_b (
        .clk(clk), .n_rst(n_rst), .tx_req(b_req), .tx_data_in(b_din),
        .tx_ack(b_ack), .tx_data(b_txd), .load_data(b_load),
        .tx_enable(b_en), .shift_strobe(b_stb), .sr_out(b_sro),
        .serial_line(b_line), .busy(b_busy)
    );

    // External shift registers: parallel load, shift left on strobe.
    always_ff @(posedge clk) begin
        if (a_load) a_sr <= a_txd;
        else if (a_stb) a_sr <= {a_sr[6:0], 1'b0};
        if (b_load) b_sr <= b_txd;
        else if (b_stb) b_sr <= {b_sr[6:0], 1'b0};
    end
    assign a_sro = a_sr[7];
    assign b_sro = b_sr[7];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Line value k cycles after the ack cycle.
    function automatic logic exp_line(int k, int c, logic [7:0] b);
        int idx;
        if (k >= 2 && k <= 1 + c) return 1'b0;
        if (k >= 2 + c && k <= 1 + 9 * c) begin
            idx = (k - 2 - c) / c;
            return b[7 - idx];
        end
        return 1'b1;
    endfunction

    function automatic logic exp_stb(int k, int c);
        return (k >= 1 + 2 * c) && (k <= 1 + 9 * c) && ((k - 1) % c == 0);
    endfunction

    task automatic set_in(input bit sel, input logic req, input logic [7:0] d);
        if (sel) begin b_req = req; b_din = d; end
        else begin a_req = req; a_din = d; end
    endtask

    task automatic set_req(input bit sel, input logic req);
        if (sel) b_req = req;
        else a_req = req;
    endtask

    task automatic set_din(input bit sel, input logic [7:0] d);
        if (sel) b_din = d;
        else a_din = d;
    endtask

    // Returns at the falling edge of the ack cycle.
    task automatic wait_ack(input bit sel);
        int n = 0;
        bit found = 0;
        while (!found && n < 300) begin
            @(negedge clk);
            if ((sel ? b_ack : a_ack) === 1'b1) found = 1;
            else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        chk("ack_seen", 32'(found), 32'd1);
    endtask

    // Called at the falling edge of the ack cycle; ends at the last STOP cycle.
    task automatic check_frame(input bit sel, input logic [7:0] b,
                               input bit hold, input bit scramble);
        int c = sel ? 3 : 4;
        int s = sel ? 2 : 1;
        int last = 1 + (9 + s) * c;
        int nstb = 0;
        chk("ack", 32'(sel ? b_ack : a_ack), 32'd1);
        chk("busy_at_ack", 32'(sel ? b_busy : a_busy), 32'd0);
        for (int k = 1; k <= last; k++) begin
            @(posedge clk);
            #1;
            if (!hold) set_req(sel, 1'b0);
            if (scramble) set_din(sel, 8'($urandom));
            @(negedge clk);
            chk($sformatf("line k=%0d", k), 32'(sel ? b_line : a_line),
                32'(exp_line(k, c, b)));
            chk($sformatf("strobe k=%0d", k), 32'(sel ? b_stb : a_stb),
                32'(exp_stb(k, c)));
            chk($sformatf("load k=%0d", k), 32'(sel ? b_load : a_load),
                32'(k == 1));
            chk($sformatf("enable k=%0d", k), 32'(sel ? b_en : a_en),
                32'(k >= 2 + c && k <= 1 + 9 * c));
            chk($sformatf("busy k=%0d", k), 32'(sel ? b_busy : a_busy), 32'd1);
            chk($sformatf("noack k=%0d", k), 32'(sel ? b_ack : a_ack), 32'd0);
            chk($sformatf("txdata k=%0d", k), 32'(sel ? b_txd : a_txd), 32'(b));
            nstb += int'(sel ? b_stb : a_stb);
        end
        chk("strobe_count", 32'(nstb), 32'd8);
    endtask

    initial begin
        logic [7:0] r;
        n_rst = 1'b0;
        a_req = 1'b0; a_din = 8'h00;
        b_req = 1'b0; b_din = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a", {a_ack, a_load, a_en, a_stb, a_busy, a_line, a_txd},
            {6'b000001, 8'h00});
        chk("rst_b", {b_ack, b_load, b_en, b_stb, b_busy, b_line, b_txd},
            {6'b000001, 8'h00});
        @(posedge clk);
        #1 n_rst = 1'b1;

        repeat (100) begin
            @(negedge clk);
            chk("idle_a", {a_ack, a_load, a_stb, a_line}, 4'b0001);
            chk("idle_b", {b_ack, b_load, b_stb, b_line}, 4'b0001);
        end

        @(posedge clk); #1 set_in(0, 1'b1, 8'hA5);
        wait_ack(0);
        check_frame(0, 8'hA5, 0, 0);

        @(posedge clk); #1 set_in(0, 1'b1, 8'h00);
        wait_ack(0);
        check_frame(0, 8'h00, 1, 0);
        @(posedge clk); #1 set_din(0, 8'hFF);
        @(negedge clk);
        chk("b2b_ack_a", 32'(a_ack), 32'd1);
        check_frame(0, 8'hFF, 1, 0);
        @(posedge clk); #1 set_req(0, 1'b0);
        @(negedge clk);
        chk("req_drop_a", {a_ack, a_busy}, 2'b00);

        @(posedge clk); #1 set_in(1, 1'b1, 8'h81);
        wait_ack(1);
        check_frame(1, 8'h81, 1, 0);
        r = 8'($urandom);
        @(posedge clk); #1 set_din(1, r);
        @(negedge clk);
        chk("b2b_ack_b", 32'(b_ack), 32'd1);
        check_frame(1, r, 0, 0);

        r = 8'($urandom);
        @(posedge clk); #1 set_in(0, 1'b1, r);
        wait_ack(0);
        @(posedge clk); #1 set_req(0, 1'b0);
        repeat (18) @(posedge clk);
        #1;
        chk("pre_rst_enable", 32'(a_en), 32'd1);
        #1 n_rst = 1'b0;
        #1;
        chk("midrst_a", {a_ack, a_load, a_en, a_stb, a_busy, a_line, a_txd},
            {6'b000001, 8'h00});
        @(posedge clk); #1 n_rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("post_rst_idle", {a_ack, a_busy, a_load, a_line}, 4'b0001);
        end
        r = 8'($urandom);
        @(posedge clk); #1 set_in(0, 1'b1, r);
        wait_ack(0);
        check_frame(0, r, 0, 0);

        r = 8'($urandom);
        @(posedge clk); #1 set_in(0, 1'b1, r);
        wait_ack(0);
        check_frame(0, r, 0, 1);

        for (int i = 0; i < 5; i++) begin
            bit sel = (i % 2 == 1);
            r = 8'($urandom);
            @(posedge clk); #1 set_in(sel, 1'b1, r);
            wait_ack(sel);
            check_frame(sel, r, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
